// File: rtl/hid_report_engine.sv
// HID mouse report engine: accumulates signed motion and button samples, then streams
// fixed-layout reports one byte at a time, splitting motion larger than +/-127 over reports.
module hid_report_engine #(
    parameter int NUM_BUTTONS = 3,
    parameter int HAS_WHEEL   = 1,
    parameter int REPORT_ID   = 0,
    parameter int DELTA_W     = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [7:0]             in_dx,
    input  logic [7:0]             in_dy,
    input  logic [7:0]             in_dwheel,
    input  logic [NUM_BUTTONS-1:0] in_buttons,
    input  logic                   report_req,
    input  logic                   usb_configured,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   tx_last,
    output logic                   busy,
    output logic                   sat_pulse
);
    localparam int         HAS_ID   = (REPORT_ID != 0) ? 1 : 0;
    localparam int         REP_LEN  = HAS_ID + 3 + HAS_WHEEL;
    localparam logic [2:0] LAST_IDX = 3'(REP_LEN - 1);
    localparam logic [7:0] ID_BYTE  = 8'(REPORT_ID);

    typedef logic signed [DELTA_W-1:0] acc_t;
    typedef logic signed [DELTA_W:0]   wide_t;
    typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_t;

    localparam wide_t SUM_MAX   = wide_t'((1 << (DELTA_W - 1)) - 1);
    localparam wide_t SUM_MIN   = -SUM_MAX;
    localparam acc_t  CLAMP_POS = acc_t'(8'sd127);
    localparam acc_t  CLAMP_NEG = -CLAMP_POS;

    // Symmetric saturating add; returns {saturated, sum}.
    function automatic logic [DELTA_W:0] sat_add(input acc_t a, input logic [7:0] d);
        wide_t sum;
        logic  sat;
        acc_t  res;
        sum = wide_t'(a) + wide_t'($signed(d));
        if (sum > SUM_MAX) begin
            sat = 1'b1;
            res = acc_t'(SUM_MAX);
        end else if (sum < SUM_MIN) begin
            sat = 1'b1;
            res = acc_t'(SUM_MIN);
        end else begin
            sat = 1'b0;
            res = acc_t'(sum);
        end
        return {sat, res};
    endfunction

    function automatic acc_t clamp127(input acc_t a);
        acc_t r;
        if (a > CLAMP_POS) begin
            r = CLAMP_POS;
        end else if (a < CLAMP_NEG) begin
            r = CLAMP_NEG;
        end else begin
            r = a;
        end
        return r;
    endfunction

    function automatic logic [7:0] byte_sel(input logic [2:0] idx, input logic [7:0] b,
                                            input logic [7:0] x, input logic [7:0] y,
                                            input logic [7:0] w);
        logic [2:0] k;
        logic [7:0] r;
        k = idx - 3'(HAS_ID);
        if ((HAS_ID != 0) && (idx == 3'd0)) begin
            r = ID_BYTE;
        end else begin
            case (k)
                3'd0:    r = b;
                3'd1:    r = x;
                3'd2:    r = y;
                3'd3:    r = w;
                default: r = 8'h00;
            endcase
        end
        return r;
    endfunction

    state_t             state_q;
    acc_t               acc_x_q, acc_y_q, acc_w_q;
    acc_t               acc_x_d, acc_y_d, acc_w_d;
    logic               pend_q, sat_q, sat_d;
    logic [7:0]         btn_q;
    logic [7:0]         snap_b_q, snap_x_q, snap_y_q, snap_w_q;
    logic [2:0]         idx_q;
    logic [7:0]         tx_data_q;
    logic               tx_valid_q, tx_last_q;

    logic               start_s, xfer_s, final_s, any_nz_s;
    logic [7:0]         dw_s;
    logic [2:0]         nxt_idx_s;
    acc_t               sent_x_s, sent_y_s, sent_w_s;
    acc_t               base_x_s, base_y_s, base_w_s;
    logic [DELTA_W:0]   res_x_s, res_y_s, res_w_s;

    // Accumulator next-state: drain the snapshot on report start, then add this cycle's deltas.
    always_comb begin
        start_s   = (state_q == IDLE) && usb_configured && (report_req || pend_q);
        xfer_s    = (state_q == SEND) && tx_valid_q && tx_ready;
        final_s   = xfer_s && tx_last_q;
        nxt_idx_s = idx_q + 3'd1;
        dw_s      = (HAS_WHEEL != 0) ? in_dwheel : 8'h00;
        sent_x_s  = clamp127(acc_x_q);
        sent_y_s  = clamp127(acc_y_q);
        sent_w_s  = clamp127(acc_w_q);
        base_x_s  = start_s ? (acc_x_q - sent_x_s) : acc_x_q;
        base_y_s  = start_s ? (acc_y_q - sent_y_s) : acc_y_q;
        base_w_s  = start_s ? (acc_w_q - sent_w_s) : acc_w_q;
        res_x_s   = sat_add(base_x_s, in_dx);
        res_y_s   = sat_add(base_y_s, in_dy);
        res_w_s   = sat_add(base_w_s, dw_s);
        if (!usb_configured) begin
            acc_x_d = '0;
            acc_y_d = '0;
            acc_w_d = '0;
            sat_d   = 1'b0;
        end else if (in_valid) begin
            acc_x_d = res_x_s[DELTA_W-1:0];
            acc_y_d = res_y_s[DELTA_W-1:0];
            acc_w_d = res_w_s[DELTA_W-1:0];
            sat_d   = res_x_s[DELTA_W] | res_y_s[DELTA_W] | res_w_s[DELTA_W];
        end else begin
            acc_x_d = base_x_s;
            acc_y_d = base_y_s;
            acc_w_d = base_w_s;
            sat_d   = 1'b0;
        end
        any_nz_s = (acc_x_d != '0) || (acc_y_d != '0) || (acc_w_d != '0);
    end

    // Report FSM with registered byte stream, pending flag and button latch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            acc_x_q    <= '0;
            acc_y_q    <= '0;
            acc_w_q    <= '0;
            pend_q     <= 1'b0;
            sat_q      <= 1'b0;
            btn_q      <= 8'h00;
            snap_b_q   <= 8'h00;
            snap_x_q   <= 8'h00;
            snap_y_q   <= 8'h00;
            snap_w_q   <= 8'h00;
            idx_q      <= 3'd0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            tx_last_q  <= 1'b0;
        end else begin
            acc_x_q <= acc_x_d;
            acc_y_q <= acc_y_d;
            acc_w_q <= acc_w_d;
            sat_q   <= sat_d;
            if (!usb_configured) begin
                btn_q <= 8'h00;
            end else if (in_valid) begin
                btn_q <= 8'(in_buttons);
            end else begin
                btn_q <= btn_q;
            end
            case (state_q)
                IDLE: begin
                    if (start_s) begin
                        snap_b_q   <= btn_q;
                        snap_x_q   <= sent_x_s[7:0];
                        snap_y_q   <= sent_y_s[7:0];
                        snap_w_q   <= sent_w_s[7:0];
                        idx_q      <= 3'd0;
                        tx_data_q  <= byte_sel(3'd0, btn_q, sent_x_s[7:0], sent_y_s[7:0],
                                               sent_w_s[7:0]);
                        tx_valid_q <= 1'b1;
                        tx_last_q  <= 1'b0;
                        pend_q     <= 1'b0;
                        state_q    <= SEND;
                    end else if (!usb_configured) begin
                        pend_q <= 1'b0;
                    end else begin
                        pend_q <= pend_q;
                    end
                end
                SEND: begin
                    if (!usb_configured) begin
                        tx_valid_q <= 1'b0;
                        tx_last_q  <= 1'b0;
                        pend_q     <= 1'b0;
                        state_q    <= IDLE;
                    end else begin
                        // Leftover motion keeps the stream going so big moves are split.
                        if (report_req || (final_s && any_nz_s)) begin
                            pend_q <= 1'b1;
                        end else begin
                            pend_q <= pend_q;
                        end
                        if (final_s) begin
                            tx_valid_q <= 1'b0;
                            tx_last_q  <= 1'b0;
                            state_q    <= IDLE;
                        end else if (xfer_s) begin
                            idx_q     <= nxt_idx_s;
                            tx_data_q <= byte_sel(nxt_idx_s, snap_b_q, snap_x_q, snap_y_q,
                                                  snap_w_q);
                            tx_last_q <= (nxt_idx_s == LAST_IDX);
                        end else begin
                            idx_q <= idx_q;
                        end
                    end
                end
                default: begin
                    tx_valid_q <= 1'b0;
                    tx_last_q  <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign tx_last   = tx_last_q;
    assign busy      = (state_q == SEND);
    assign sat_pulse = sat_q;

endmodule

// File: doc/hid_report_engine.md
HID_REPORT_ENGINE -- requirements
Module: hid_report_engine

Interface
REQ-001 Parameter NUM_BUTTONS, default 3, SHALL set the number of button bits (legal 1..8).
REQ-002 Parameter HAS_WHEEL, default 1, SHALL append a wheel byte to the report when 1.
REQ-003 Parameter REPORT_ID, default 0, SHALL prepend a report-ID byte of this value when nonzero (legal 0..255).
REQ-004 Parameter DELTA_W, default 12, SHALL set the signed accumulator width (legal 9..16).
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 rst_n  in  1  reset; synchronous, active-low.
REQ-007 in_valid  in  1  one motion/button sample presented this cycle.
REQ-008 in_dx, in_dy, in_dwheel  in  8 each  signed two's-complement deltas.
REQ-009 in_buttons  in  NUM_BUTTONS  current button state; bit0 = left.
REQ-010 report_req  in  1  request one report.
REQ-011 usb_configured  in  1  host has configured the device.
REQ-012 tx_data  out  8  report byte.
REQ-013 tx_valid  out  1  tx_data is valid.
REQ-014 tx_ready  in  1  USB core accepts the byte this cycle.
REQ-015 tx_last  out  1  final byte of the report.
REQ-016 busy  out  1  report in progress.
REQ-017 sat_pulse  out  1  one-cycle pulse when any accumulator saturates.

Function
REQ-018 Report length SHALL be L = (REPORT_ID!=0) + 3 + HAS_WHEEL bytes, in order: [ID], buttons, X, Y, [wheel].
REQ-019 The buttons byte SHALL be the latched buttons, zero-padded in bits 7..NUM_BUTTONS.
REQ-020 On in_valid, acc_x/acc_y/acc_w SHALL add the sign-extended delta, saturating to ±(2^(DELTA_W-1)-1); sat_pulse SHALL assert in the following cycle.
REQ-021 On in_valid, the button latch SHALL take in_buttons.
REQ-022 States SHALL be IDLE and SEND; busy = (state==SEND).
REQ-023 In IDLE, when usb_configured=1 and (report_req=1 or pend=1), at that edge the block SHALL snapshot sent_v = clamp(acc_v, -127, +127) per axis, SHALL load acc_v <= acc_v - sent_v (+ the delta if in_valid in the same cycle), SHALL clear pend, and SHALL enter SEND with tx_valid=1 and tx_data = first byte.
REQ-024 A byte transfers when tx_valid and tx_ready are both 1; tx_data and tx_last SHALL be held stable while tx_valid=1 and tx_ready=0.
REQ-025 On a non-final transfer, the next byte SHALL be presented in the next cycle with no bubble.
REQ-026 On the final transfer, the block SHALL set tx_valid=0 and tx_last=0 and return to IDLE; the next report SHALL start no earlier than one cycle later.
REQ-027 tx_last SHALL equal 1 exactly while the byte-L is presented.
REQ-028 report_req seen while busy=1 SHALL set pend.
REQ-029 At the final transfer, pend SHALL also be set if any accumulator (including deltas arriving that cycle) is nonzero, so large motion is split across consecutive reports.
REQ-030 While usb_configured=0, accumulators, pend and the button latch SHALL be held at 0 and in_valid ignored.
REQ-031 If usb_configured falls while in SEND, the block SHALL set tx_valid=0 and tx_last=0 and enter IDLE at the next edge (report aborted).

Reset
REQ-032 With rst_n=0 at an edge, the block SHALL set state IDLE; tx_data=0x00, tx_valid=0, tx_last=0, busy=0, sat_pulse=0; accumulators, pend and latches SHALL be 0, including when reset occurs mid-report.

Verification (defaults unless stated; usb_configured=1, tx_ready=1)
REQ-033 Basic: in_valid with dx=0x05, dy=0xFD, dw=0x01, buttons=3'b101, then report_req -> bytes 05,05,FD,01 on 4 consecutive cycles; tx_last on 01; busy low afterwards.
REQ-034 Split: dx=+100 three times (acc 300), one report_req -> three reports with X=7F, 7F, 2E; then IDLE with acc_x=0.
REQ-035 Backpressure: tx_ready=0 for 3 cycles while the X byte is presented -> tx_data held, tx_valid=1; the sequence then completes unchanged.
REQ-036 Saturation: 17 samples of dx=+127 -> acc_x=2047, one sat_pulse; report X=7F; residual 1920 is drained by automatic follow-on reports.
REQ-037 REPORT_ID=0x02, HAS_WHEEL=0, buttons=3'b010, dx=dy=0 -> bytes 02,02,00,00, tx_last on the 4th.
REQ-038 usb_configured dropped during the Y byte -> tx_valid=0 next cycle; acc=0; no report after reconfigure until a new report_req.
